// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch lap controller.
// Contents:
//   status_e  - externally visible status encoding (also the FSM state type)
//   SEC_MAX   - last seconds value before rolling into the next minute
//   SEC_W     - width of the seconds fields
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StRunning   = 2'b01,
    StPaused    = 2'b10,
    StSaturated = 2'b11
  } status_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned SEC_W   = 6;

endpackage

// File: rtl/stopwatch_lap_fifo.sv
// Synchronous FIFO holding captured lap times.
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2).
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush        - synchronous empty; overrides push/pop
//   push, wdata  - write request and data
//   pop          - remove head; ignored when empty
//   rdata        - head entry (meaningful while !empty)
//   full, empty  - occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module stopwatch_lap_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch control and timekeeping core: start/stop/clear FSM, one-second tick
// prescaler, minutes:seconds counter and a lap-capture FIFO.
// Optional build macro STOPWATCH_WRAP_EN: when defined, a tick at MAX_MIN:59 wraps
// to 00:00 and the block keeps running (no saturation).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, stop, clear  - single-cycle command pulses (clear > stop > start)
//   lap, lap_rd         - capture current time / pop lap FIFO head
//   status              - 00 idle, 01 running, 10 paused, 11 saturated
//   minutes, seconds    - elapsed time
//   lap_valid, lap_min, lap_sec, lap_full - lap FIFO head and flags
//   lap_drop            - sticky: a lap was lost to a full FIFO
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100,
  parameter int unsigned MAX_MIN   = 99,
  parameter int unsigned MIN_W     = 7,
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             lap,
  input  logic             lap_rd,
  output logic [1:0]       status,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] seconds,
  output logic             lap_valid,
  output logic [MIN_W-1:0] lap_min,
  output logic [SEC_W-1:0] lap_sec,
  output logic             lap_full,
  output logic             lap_drop
);

  localparam int unsigned       PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [MIN_W-1:0]  MIN_LAST   = MIN_W'(MAX_MIN);
  localparam logic [SEC_W-1:0]  SEC_LAST   = SEC_W'(SEC_MAX);

  status_e          state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic             drop_q, drop_d;

  logic running, tick, at_max;
  logic lap_push, lap_pop, fifo_full, fifo_empty;
  logic [MIN_W+SEC_W-1:0] fifo_head;

  assign running = (state_q == StRunning);
  assign tick    = running && (presc_q == PRESC_LAST);
  assign at_max  = (min_q == MIN_LAST) && (sec_q == SEC_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    min_d   = min_q;
    sec_d   = sec_q;
    if (clear) begin
      state_d = StIdle;
      presc_d = '0;
      min_d   = '0;
      sec_d   = '0;
    end else begin
      if (running) begin
        presc_d = tick ? '0 : presc_q + 1'b1;
      end
      if (tick) begin
        if (sec_q < SEC_LAST) begin
          sec_d = sec_q + 1'b1;
        end else if (!at_max) begin
          sec_d = '0;
          min_d = min_q + 1'b1;
        end
`ifdef STOPWATCH_WRAP_EN
        else begin
          sec_d = '0;
          min_d = '0;
        end
`endif
      end
      // stop outranks start, so a stop pulse masks a same-cycle start.
      case (state_q)
        StIdle: begin
          if (!stop && start) state_d = StRunning;
        end
        StRunning: begin
          if (stop) begin
            state_d = StPaused;
          end
`ifndef STOPWATCH_WRAP_EN
          else if (tick && at_max) begin
            state_d = StSaturated;
          end
`endif
        end
        StPaused: begin
          if (!stop && start) state_d = StRunning;
        end
        StSaturated: state_d = StSaturated;
        default:     state_d = StIdle;
      endcase
    end
  end

  // Laps capture the time shown this cycle, before any same-cycle tick.
  assign lap_push = !clear && lap && (state_q == StRunning || state_q == StPaused);
  assign lap_pop  = !clear && lap_rd;
  assign drop_d   = clear ? 1'b0 : (drop_q || (lap_push && fifo_full && !lap_pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      drop_q  <= drop_d;
    end
  end

  stopwatch_lap_fifo #(
    .WIDTH (MIN_W + SEC_W),
    .DEPTH (LAP_DEPTH)
  ) u_lap_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (lap_push),
    .wdata ({min_q, sec_q}),
    .pop   (lap_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign status    = state_q;
  assign minutes   = min_q;
  assign seconds   = sec_q;
  assign lap_valid = !fifo_empty;
  assign lap_full  = fifo_full;
  assign lap_min   = fifo_head[MIN_W+SEC_W-1:SEC_W];
  assign lap_sec   = fifo_head[SEC_W-1:0];
  assign lap_drop  = drop_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Bench for stopwatch_lap_ctrl (TICK_DIV=4, MAX_MIN=2, LAP_DEPTH=4).
// The reference model tracks elapsed time as a total second count plus a
// within-second cycle phase, and laps as a queue of total seconds.
module tb_stopwatch_lap_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int MAX_MIN   = 2;
  localparam int MIN_W     = 7;
  localparam int LAP_DEPTH = 4;
  localparam int LAST      = MAX_MIN * 60 + 59;

  logic             clk, rst_n;
  logic             start, stop, clear, lap, lap_rd;
  logic [1:0]       status;
  logic [MIN_W-1:0] minutes, lap_min;
  logic [5:0]       seconds, lap_sec;
  logic             lap_valid, lap_full, lap_drop;

  stopwatch_lap_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .MAX_MIN   (MAX_MIN),
    .MIN_W     (MIN_W),
    .LAP_DEPTH (LAP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .lap       (lap),
    .lap_rd    (lap_rd),
    .status    (status),
    .minutes   (minutes),
    .seconds   (seconds),
    .lap_valid (lap_valid),
    .lap_min   (lap_min),
    .lap_sec   (lap_sec),
    .lap_full  (lap_full),
    .lap_drop  (lap_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int status;
    int mn;
    int sc;
    int v;
    int full;
    int drop;
    int hmin;
    int hsec;
  } snap_t;

  snap_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 running, 2 paused, 3 saturated.
  int m_mode, m_phase, m_elapsed, m_drop;
  int m_laps[$];

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_elapsed = 0; m_drop = 0;
    m_laps.delete();
  endtask

  task automatic model_step(input bit st, input bit sp, input bit cl, input bit lp,
                            input bit rd);
    bit tick, sat;
    if (cl) begin
      model_reset();
      return;
    end
    tick = (m_mode == 1) && (m_phase == TICK_DIV - 1);
    sat  = 1'b0;
    if (rd && m_laps.size() > 0) void'(m_laps.pop_front());
    if (lp && (m_mode == 1 || m_mode == 2)) begin
      if (m_laps.size() < LAP_DEPTH) m_laps.push_back(m_elapsed);
      else m_drop = 1;
    end
    if (m_mode == 1) m_phase = (m_phase + 1) % TICK_DIV;
    if (tick) begin
      if (m_elapsed < LAST) m_elapsed++;
`ifdef STOPWATCH_WRAP_EN
      else m_elapsed = 0;
`else
      else sat = 1'b1;
`endif
    end
    if (m_mode == 1 && sp) m_mode = 2;
    else if (sat) m_mode = 3;
    else if ((m_mode == 0 || m_mode == 2) && st && !sp) m_mode = 1;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.status = m_mode;
    s.mn     = m_elapsed / 60;
    s.sc     = m_elapsed % 60;
    s.v      = (m_laps.size() > 0) ? 1 : 0;
    s.full   = (m_laps.size() == LAP_DEPTH) ? 1 : 0;
    s.drop   = m_drop;
    s.hmin   = s.v ? m_laps[0] / 60 : 0;
    s.hsec   = s.v ? m_laps[0] % 60 : 0;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input bit st, input bit sp, input bit cl, input bit lp, input bit rd);
    @(negedge clk);
    start = st; stop = sp; clear = cl; lap = lp; lap_rd = rd;
    model_step(st, sp, cl, lp, rd);
    exp_q.push_back(model_snap());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Monitor: compare each queued expectation just after the edge it refers to.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("status", int'(status), e.status);
        chk("minutes", int'(minutes), e.mn);
        chk("seconds", int'(seconds), e.sc);
        chk("lap_valid", int'(lap_valid), e.v);
        chk("lap_full", int'(lap_full), e.full);
        chk("lap_drop", int'(lap_drop), e.drop);
        if (e.v != 0) begin
          chk("lap_min", int'(lap_min), e.hmin);
          chk("lap_sec", int'(lap_sec), e.hsec);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bit cl, sp, st, lp, rd;
    start = 0; stop = 0; clear = 0; lap = 0; lap_rd = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    exp_q.push_back(model_snap());
    @(negedge clk);
    rst_n = 1'b1;

    // Start, first ticks, pause mid-second and resume.
    step(1, 0, 0, 0, 0);
    idle(9);
    step(0, 1, 0, 0, 0);
    idle(10);
    step(1, 0, 0, 0, 0);
    idle(3);

    // Run into saturation, ignored start, then clear.
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    idle(4 * (LAST + 1) + 2);
    step(1, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0);
    idle(2);

    // Five laps into a four-entry FIFO, then drain it past empty.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      idle(5);
      step(0, 0, 0, 1, 0);
    end
    idle(2);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);

    // Refill, then lap with pop while full, then clear+lap+start together.
    for (int i = 0; i < 4; i++) begin
      idle(3);
      step(0, 0, 0, 1, 0);
    end
    step(0, 0, 0, 1, 1);
    idle(2);
    step(1, 0, 1, 1, 0);
    idle(3);

    // Random traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      r  = $urandom_range(0, 99);
      cl = (r < 2);
      sp = (r >= 2 && r < 6);
      st = (r >= 6 && r < 16);
      lp = ($urandom_range(0, 99) < 15);
      rd = ($urandom_range(0, 99) < 15);
      step(st, sp, cl, lp, rd);
    end
    // Long random run without clears so the counter can reach its limit.
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 2500; i++) begin
      r  = $urandom_range(0, 99);
      sp = (r < 1);
      st = (r >= 1 && r < 11);
      lp = ($urandom_range(0, 99) < 10);
      rd = ($urandom_range(0, 99) < 10);
      step(st, sp, 0, lp, rd);
    end

    idle(1);
    @(negedge clk);
    start = 0; stop = 0; clear = 0; lap = 0; lap_rd = 0;
    @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Parametrised stopwatch control and timekeeping core. It combines the start/stop/clear control FSM with a tick prescaler, a minutes:seconds counter, and a lap-capture FIFO. It sits between the debounced button pulses and the display/readout logic, and is the next generation of the stopwatch control block.

Parameters:
TICK_DIV, 100, clk cycles per one-second tick (>=2)
MAX_MIN, 99, highest minute value reached before saturation (<= 2**MIN_W-1)
MIN_W, 7, width of minutes fields
LAP_DEPTH, 4, lap FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  single-cycle pulse: start/resume
stop  in  1  single-cycle pulse: pause
clear  in  1  single-cycle pulse: synchronous clear to IDLE
lap  in  1  single-cycle pulse: capture current time into FIFO
lap_rd  in  1  pop FIFO head
status  out  2  00 IDLE, 01 RUNNING, 10 PAUSED, 11 SATURATED
minutes  out  MIN_W  elapsed minutes
seconds  out  6  elapsed seconds, 0..59
lap_valid  out  1  FIFO non-empty
lap_min  out  MIN_W  FIFO head minutes
lap_sec  out  6  FIFO head seconds
lap_full  out  1  FIFO holds LAP_DEPTH entries
lap_drop  out  1  sticky: a lap was discarded because the FIFO was full

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. Reset drives all outputs and internal state to 0: status=IDLE, time 00:00, prescaler 0, FIFO empty, lap_drop=0.
- Command priority within one cycle: clear > stop > start. lap and lap_rd are evaluated independently of these.
- Transitions are registered and take effect on the next clk edge:
  - IDLE: start -> RUNNING.
  - RUNNING: stop -> PAUSED.
  - PAUSED: start -> RUNNING. Prescaler and time are held, so resume continues the partial second.
  - SATURATED: start and stop are ignored.
  - Any state: clear -> IDLE. Clear zeroes time and prescaler, empties the FIFO and clears lap_drop.
  - Commands not listed above are ignored, e.g. start in RUNNING or stop in IDLE.
- Prescaler counts 0..TICK_DIV-1 only while status==RUNNING.
  - Tick is asserted on the cycle where prescaler==TICK_DIV-1 and RUNNING. On that cycle the prescaler wraps to 0.
  - First seconds increment occurs TICK_DIV cycles after status becomes RUNNING.
  - If stop and tick coincide, the tick still applies this edge and the state goes to PAUSED.
- On tick:
  - seconds<59: seconds+1.
  - seconds==59 and minutes<MAX_MIN: seconds=0, minutes+1.
  - At MAX_MIN:59: time holds and status goes to SATURATED.
- lap is accepted only in RUNNING or PAUSED.
  - It pushes the time currently on minutes/seconds (the value before any same-cycle increment).
  - If the FIFO is full and lap_rd is not asserted the same cycle, the entry is dropped and lap_drop is set.
  - Full with simultaneous lap_rd: pop and push both occur; no drop.
  - lap is ignored in IDLE and SATURATED.
- FIFO head (lap_min/lap_sec) is valid while lap_valid is high and shows first-in data. lap_rd on an empty FIFO is ignored.
- clear coinciding with lap or lap_rd: clear wins and the FIFO is empty afterwards.
- Illegal status encodings cannot occur; the default branch recovers to IDLE.

Optional Feature:
Macro STOPWATCH_WRAP_EN.
- Defined: a tick at MAX_MIN:59 wraps time to 00:00 and the block stays RUNNING. SATURATED is unreachable.
- Undefined: saturation behaviour as described above.

Decomposition:
- Package stopwatch_pkg holds the status encoding constants (IDLE/RUNNING/PAUSED/SATURATED), SEC_MAX=59 and SEC_W=6.
- One sub-module, stopwatch_lap_fifo: synchronous FIFO, parametrised on width and depth, with push/pop/full/empty. The simultaneous push+pop-when-full rule is implemented inside it.

Test Plan:
All scenarios use TICK_DIV=4, MAX_MIN=2, LAP_DEPTH=4.
- Reset then start pulse -> status=01 next cycle; seconds=1 exactly 4 cycles later; seconds=2 after 8 cycles.
- Run to 00:02 plus 2 prescaler cycles, stop, wait 10 cycles, start -> time holds 00:02 while paused; seconds=3 two cycles after resume.
- Run to 02:59 -> next tick gives status=11 and time stays 02:59; start ignored; clear -> status=00, 00:00.
- With STOPWATCH_WRAP_EN defined, same run -> time 00:00 after 02:59, status stays 01.
- Five lap pulses at distinct times with no lap_rd -> lap_full=1, lap_drop=1; four pops return the first four times in order, then lap_valid=0.
- Same cycle clear+lap+start while RUNNING -> status=00, FIFO empty, lap_drop=0, time 00:00.
